// File: rtl/muacm_tx_arbiter_if.sv
// muacm_tx_arbiter_if: requester-side byte streams plus the shared muACM TX port.
interface muacm_tx_arbiter_if #(parameter int N = 2);
  logic [8*N-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [7:0]     o_data;
  logic           o_last;
  logic           o_valid;
  logic           o_ready;
  logic [N-1:0]   o_grant;
  logic           o_busy;
  modport slave (
    input  in_data, in_last, in_valid, o_ready,
    output in_ready, o_data, o_last, o_valid, o_grant, o_busy
  );
  modport master (
    output in_data, in_last, in_valid, o_ready,
    input  in_ready, o_data, o_last, o_valid, o_grant, o_busy
  );
endinterface

// File: rtl/muacm_tx_arbiter.sv
// muacm_tx_arbiter: packet-locked round-robin share of the muACM TX byte port, grants capped at MAX_LEN bytes.
module muacm_tx_arbiter #(
  parameter int N       = 2,
  parameter int MAX_LEN = 64
) (
  input logic               i_clk,
  input logic               rst,
  muacm_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_LEN);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IW-1:0]  gidx_q, gidx_d, ptr_q, ptr_d, pick, idx;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           found, beat, busy;
  assign busy         = (state_q == GRANT);
  assign bus.o_busy   = busy;
  assign bus.o_grant  = grant_q;
  assign bus.o_data   = bus.in_data[8*gidx_q +: 8];
  assign bus.o_valid  = busy & bus.in_valid[gidx_q];
  assign bus.o_last   = busy & (bus.in_last[gidx_q] | (cnt_q == CW'(MAX_LEN - 1)));
  assign bus.in_ready = grant_q & {N{bus.o_ready}};
  assign beat         = bus.o_valid & bus.o_ready;
  // Round-robin search starts just after the last requester to finish a grant.
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(ptr_q) + i) % N);
      if (!found && bus.in_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (!busy) begin
      state_d = found ? GRANT : IDLE;
      gidx_d  = found ? pick : gidx_q;
      grant_d = found ? ({{(N-1){1'b0}}, 1'b1} << pick) : '0;
    end else if (beat) begin
      cnt_d   = bus.o_last ? '0 : cnt_q + 1'b1;
      state_d = bus.o_last ? IDLE : GRANT;
      grant_d = bus.o_last ? '0 : grant_q;
      ptr_d   = bus.o_last ? gidx_q : ptr_q;
    end
  end
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= IW'(N - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_muacm_tx_arbiter.sv
// tb_muacm_tx_arbiter: directed checks of grant order, packet locking, length cap, stalls and reset.
module tb_muacm_tx_arbiter;
  localparam int N = 4;
  localparam int MAX_LEN = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  muacm_tx_arbiter_if #(.N(N)) b ();
  muacm_tx_arbiter #(.N(N), .MAX_LEN(MAX_LEN)) dut (.i_clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_src(input int k, input logic [7:0] d, input logic l);
    b.in_data[8*k +: 8] = d;
    b.in_last[k] = l;
  endtask
  initial begin
    b.in_data = '0;
    b.in_last = '0;
    b.in_valid = '0;
    b.o_ready = 1'b0;
    step();
    step();
    chk("rst_grant", b.o_grant, 0);
    chk("rst_busy", b.o_busy, 0);
    chk("rst_valid", b.o_valid, 0);
    chk("rst_ready", b.in_ready, 0);
    rst = 1'b0;
    // 1: single 3-byte packet from req0
    b.o_ready = 1'b1;
    set_src(0, 8'h41, 1'b0);
    b.in_valid = 4'b0001;
    #1;
    chk("t1_idle_busy", b.o_busy, 0);
    chk("t1_idle_valid", b.o_valid, 0);
    step();
    chk("t1_grant", b.o_grant, 4'b0001);
    chk("t1_b0", b.o_data, 8'h41);
    chk("t1_b0_last", b.o_last, 0);
    chk("t1_inready", b.in_ready, 4'b0001);
    step();
    set_src(0, 8'h42, 1'b0);
    #1;
    chk("t1_b1", b.o_data, 8'h42);
    chk("t1_b1_valid", b.o_valid, 1);
    step();
    set_src(0, 8'h43, 1'b1);
    #1;
    chk("t1_b2", b.o_data, 8'h43);
    chk("t1_b2_last", b.o_last, 1);
    step();
    b.in_valid = '0;
    set_src(0, 8'h00, 1'b0);
    #1;
    chk("t1_end_grant", b.o_grant, 0);
    chk("t1_end_busy", b.o_busy, 0);
    // 2: req0 and req1 together after reset, no interleave
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_src(0, 8'hA0, 1'b0);
    set_src(1, 8'hB0, 1'b0);
    b.in_valid = 4'b0011;
    step();
    chk("t2_g0", b.o_grant, 4'b0001);
    chk("t2_a0", b.o_data, 8'hA0);
    step();
    set_src(0, 8'hA1, 1'b1);
    #1;
    chk("t2_a1", b.o_data, 8'hA1);
    chk("t2_a1_last", b.o_last, 1);
    chk("t2_a1_ready", b.in_ready, 4'b0001);
    step();
    b.in_valid = 4'b0010;
    #1;
    chk("t2_bubble_busy", b.o_busy, 0);
    chk("t2_bubble_valid", b.o_valid, 0);
    step();
    chk("t2_g1", b.o_grant, 4'b0010);
    chk("t2_b0", b.o_data, 8'hB0);
    chk("t2_b0_ready", b.in_ready, 4'b0010);
    step();
    set_src(1, 8'hB1, 1'b1);
    #1;
    chk("t2_b1", b.o_data, 8'hB1);
    chk("t2_b1_last", b.o_last, 1);
    step();
    b.in_valid = '0;
    #1;
    chk("t2_end_grant", b.o_grant, 0);
    // 3: all four continuously valid, 1-byte packets -> 0,1,2,3,0,1,2,3
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < N; k++) set_src(k, 8'h10 + 8'(k), 1'b1);
    b.in_valid = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      step();
      chk("t3_grant", b.o_grant, 32'(1) << (n % 4));
      chk("t3_data", b.o_data, 32'h10 + 32'(n % 4));
      chk("t3_last", b.o_last, 1);
      step();
      if (n == 7) b.in_valid = '0;
      #1;
      chk("t3_bubble", b.o_busy, 0);
    end
    b.in_last = '0;
    // 4: req1 70-byte packet capped at 64, req2 waiting
    set_src(1, 8'd1, 1'b0);
    set_src(2, 8'hC0, 1'b1);
    b.in_valid = 4'b0110;
    step();
    chk("t4_g1", b.o_grant, 4'b0010);
    for (int i = 1; i <= 64; i++) begin
      chk("t4_data_a", b.o_data, 32'(i));
      chk("t4_last_a", b.o_last, 32'(i == 64));
      step();
      set_src(1, 8'(i + 1), 1'b0);
      #1;
    end
    chk("t4_cap_idle", b.o_busy, 0);
    step();
    chk("t4_g2", b.o_grant, 4'b0100);
    chk("t4_c0", b.o_data, 8'hC0);
    chk("t4_c0_last", b.o_last, 1);
    step();
    b.in_valid = 4'b0010;
    #1;
    chk("t4_bubble2", b.o_busy, 0);
    step();
    chk("t4_g1_again", b.o_grant, 4'b0010);
    for (int i = 65; i <= 70; i++) begin
      chk("t4_data_b", b.o_data, 32'(i));
      chk("t4_last_b", b.o_last, 32'(i == 70));
      step();
      if (i < 70) set_src(1, 8'(i + 1), i + 1 == 70);
      else b.in_valid = '0;
      #1;
    end
    chk("t4_end_grant", b.o_grant, 0);
    set_src(1, 8'h00, 1'b0);
    set_src(2, 8'h00, 1'b0);
    // 5: o_ready toggling during a 4-byte packet from req3, req0 waiting
    b.o_ready = 1'b0;
    set_src(3, 8'hD1, 1'b0);
    set_src(0, 8'hEE, 1'b1);
    b.in_valid = 4'b1001;
    step();
    chk("t5_g3", b.o_grant, 4'b1000);
    for (int i = 1; i <= 4; i++) begin
      b.o_ready = 1'b0;
      #1;
      chk("t5_stall_ready", b.in_ready, 0);
      chk("t5_stall_data", b.o_data, 32'hD0 + 32'(i));
      chk("t5_stall_valid", b.o_valid, 1);
      step();
      b.o_ready = 1'b1;
      #1;
      chk("t5_go_ready", b.in_ready, 4'b1000);
      chk("t5_go_data", b.o_data, 32'hD0 + 32'(i));
      chk("t5_go_last", b.o_last, 32'(i == 4));
      step();
      if (i < 4) set_src(3, 8'hD0 + 8'(i + 1), i + 1 == 4);
      else b.in_valid = '0;
    end
    #1;
    chk("t5_end_busy", b.o_busy, 0);
    set_src(0, 8'h00, 1'b0);
    set_src(3, 8'h00, 1'b0);
    // 6: reset in the middle of a 5-byte packet
    b.o_ready = 1'b1;
    set_src(1, 8'h99, 1'b0);
    set_src(0, 8'h51, 1'b0);
    b.in_valid = 4'b0001;
    step();
    chk("t6_g0", b.o_grant, 4'b0001);
    step();
    set_src(0, 8'h52, 1'b0);
    #1;
    chk("t6_b2", b.o_data, 8'h52);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", b.o_valid, 0);
    chk("t6_rst_ready", b.in_ready, 0);
    chk("t6_rst_grant", b.o_grant, 0);
    step();
    rst = 1'b0;
    b.in_valid = 4'b0011;
    step();
    chk("t6_regrant", b.o_grant, 4'b0001);
    chk("t6_regrant_data", b.o_data, 8'h52);
    b.in_valid = '0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
